// File: rtl/cv32e40p_tb_status_periph_if.sv
// Data-bus port bundle between the core-side master and the status peripheral.
// The grant is combinational and the response arrives one cycle after it.
interface cv32e40p_tb_status_periph_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/cv32e40p_tb_status_periph.sv
// Testbench status peripheral: stdout FIFO, pass/fail/exit reporting deferred
// until the FIFO drains, and a one-shot countdown timer interrupt.
module cv32e40p_tb_status_periph #(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter logic [31:0] PASS_MAGIC = 32'd123456789
) (
    input  logic                              clk,
    input  logic                              rst,
    cv32e40p_tb_status_periph_if.slave        bus,
    output logic                              char_valid,
    output logic [7:0]                        char_byte,
    input  logic                              char_ready,
    output logic                              tests_passed,
    output logic                              tests_failed,
    output logic                              exit_valid,
    output logic [31:0]                       exit_value,
    output logic                              irq_timer
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [31:0] ADDR_PRINT  = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEVEL  = 32'h1000_0004;
    localparam logic [31:0] ADDR_STATUS = 32'h2000_0000;
    localparam logic [31:0] ADDR_EXIT   = 32'h2000_0004;
    localparam logic [31:0] ADDR_TIMER  = 32'h1500_0000;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;
    typedef enum logic [1:0] {REQ_PASS, REQ_FAIL, REQ_EXIT} req_kind_t;

    logic             sel_print, sel_level, sel_status, sel_exit, sel_timer;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, push, pop, term_write, timer_write;
    state_t           state_q, state_d;
    req_kind_t        kind_q;
    logic             fire;
    logic [31:0]      timer_q, read_mux;
    logic             unused_be;

    assign unused_be   = ^bus.be;
    assign sel_print   = bus.addr == ADDR_PRINT;
    assign sel_level   = bus.addr == ADDR_LEVEL;
    assign sel_status  = bus.addr == ADDR_STATUS;
    assign sel_exit    = bus.addr == ADDR_EXIT;
    assign sel_timer   = bus.addr == ADDR_TIMER;

    // Only a PRINT write into a full FIFO is back-pressured.
    assign fifo_full   = count == CNT_W'(FIFO_DEPTH);
    assign bus.gnt     = bus.req & ~rst & ~(bus.we & sel_print & fifo_full);
    assign push        = bus.gnt & bus.we & sel_print;
    assign pop         = char_valid & char_ready;
    assign term_write  = bus.gnt & bus.we & (sel_status | sel_exit);
    assign timer_write = bus.gnt & bus.we & sel_timer;
    assign char_valid  = count != '0;
    assign char_byte   = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= bus.wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            IDLE:  if (term_write) state_d = DRAIN;
            DRAIN: begin
                if (!char_valid) begin
                    fire    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // First termination request wins; later ones are granted but dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kind_q       <= REQ_PASS;
            exit_value   <= '0;
            tests_passed <= 1'b0;
            tests_failed <= 1'b0;
            exit_valid   <= 1'b0;
        end else begin
            if (state_q == IDLE && term_write) begin
                if (sel_exit) begin
                    kind_q     <= REQ_EXIT;
                    exit_value <= bus.wdata;
                end else if (bus.wdata == PASS_MAGIC) begin
                    kind_q <= REQ_PASS;
                end else begin
                    kind_q <= REQ_FAIL;
                end
            end
            tests_passed <= fire && kind_q == REQ_PASS;
            tests_failed <= fire && kind_q == REQ_FAIL;
            exit_valid   <= fire && kind_q == REQ_EXIT;
        end
    end

    // A TIMER write overrides the countdown, including its final 1->0 step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q   <= '0;
            irq_timer <= 1'b0;
        end else if (timer_write) begin
            timer_q   <= bus.wdata;
            irq_timer <= 1'b0;
        end else if (timer_q != '0) begin
            timer_q <= timer_q - 32'd1;
            if (timer_q == 32'd1) irq_timer <= 1'b1;
        end
    end

    always_comb begin
        read_mux = '0;
        if (sel_level)      read_mux = 32'(count);
        else if (sel_timer) read_mux = timer_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.rvalid <= 1'b0;
            bus.rdata  <= '0;
        end else begin
            bus.rvalid <= bus.gnt;
            bus.rdata  <= (bus.gnt && !bus.we) ? read_mux : '0;
        end
    end

endmodule

// File: tb/tb_cv32e40p_tb_status_periph.sv
// Self-checking bench: directed scenarios followed by random bus traffic, all
// compared cycle by cycle against a queue/arithmetic model of the peripheral.
module tb_cv32e40p_tb_status_periph;

    localparam int unsigned FIFO_DEPTH  = 8;
    localparam logic [31:0] PASS_MAGIC  = 32'd123456789;
    localparam logic [31:0] ADDR_PRINT  = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEVEL  = 32'h1000_0004;
    localparam logic [31:0] ADDR_STATUS = 32'h2000_0000;
    localparam logic [31:0] ADDR_EXIT   = 32'h2000_0004;
    localparam logic [31:0] ADDR_TIMER  = 32'h1500_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        char_valid, char_ready;
    logic [7:0]  char_byte;
    logic        tests_passed, tests_failed, exit_valid, irq_timer;
    logic [31:0] exit_value;

    cv32e40p_tb_status_periph_if bus ();

    cv32e40p_tb_status_periph #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PASS_MAGIC (PASS_MAGIC)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .char_valid   (char_valid),
        .char_byte    (char_byte),
        .char_ready   (char_ready),
        .tests_passed (tests_passed),
        .tests_failed (tests_failed),
        .exit_valid   (exit_valid),
        .exit_value   (exit_value),
        .irq_timer    (irq_timer)
    );

    always #5 clk = ~clk;

    // Model: byte queue, termination status (0 none, 1 pending, 2 done),
    // and the last timer write recorded as (cycle, value).
    int          n_assert = 0;
    int          n_fail   = 0;
    longint      cyc      = 0;
    logic [7:0]  q [$];
    int          term     = 0;
    int          kind     = 0;
    logic [31:0] exp_exit_val = '0;
    longint      wr_cyc   = 0;
    longint      wr_n     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] timer_at(input longint k);
        longint el;
        el = k - wr_cyc - 1;
        if (wr_n == 0 || el >= wr_n) return 32'd0;
        return 32'(wr_n - el);
    endfunction

    function automatic logic irq_at(input longint k);
        return wr_n > 0 && k >= wr_cyc + wr_n + 1;
    endfunction

    // One bus cycle, entered at a falling edge; leaves at the next falling edge.
    task automatic bus_cycle(input logic r, input logic w, input logic [31:0] a,
                             input logic [31:0] d, input logic rdy);
        logic        exp_gnt;
        logic [31:0] rd;
        logic        nx_pass, nx_fail, nx_exit;
        bus.req = r; bus.we = w; bus.addr = a; bus.wdata = d; bus.be = 4'hf;
        char_ready = rdy;
        #1;
        exp_gnt = r && !(w && a == ADDR_PRINT && q.size() == FIFO_DEPTH);
        check("gnt", {31'd0, bus.gnt}, {31'd0, exp_gnt});
        rd = '0;
        if (exp_gnt && !w) begin
            if (a == ADDR_LEVEL)      rd = 32'(q.size());
            else if (a == ADDR_TIMER) rd = timer_at(cyc);
        end
        nx_pass = 1'b0; nx_fail = 1'b0; nx_exit = 1'b0;
        if (term == 1 && q.size() == 0) begin
            term    = 2;
            nx_pass = kind == 0;
            nx_fail = kind == 1;
            nx_exit = kind == 2;
        end else if (term == 0 && exp_gnt && w && (a == ADDR_STATUS || a == ADDR_EXIT)) begin
            term = 1;
            if (a == ADDR_EXIT) begin
                kind = 2;
                exp_exit_val = d;
            end else begin
                kind = (d == PASS_MAGIC) ? 0 : 1;
            end
        end
        if (q.size() > 0 && rdy) void'(q.pop_front());
        if (exp_gnt && w && a == ADDR_PRINT) q.push_back(d[7:0]);
        if (exp_gnt && w && a == ADDR_TIMER) begin
            wr_cyc = cyc;
            wr_n   = longint'(d);
        end
        @(negedge clk);
        cyc++;
        check("rvalid", {31'd0, bus.rvalid}, {31'd0, exp_gnt});
        check("rdata", bus.rdata, rd);
        check("char_valid", {31'd0, char_valid}, {31'd0, q.size() > 0});
        if (q.size() > 0) check("char", {24'd0, char_byte}, {24'd0, q[0]});
        check("tests_passed", {31'd0, tests_passed}, {31'd0, nx_pass});
        check("tests_failed", {31'd0, tests_failed}, {31'd0, nx_fail});
        check("exit_valid", {31'd0, exit_valid}, {31'd0, nx_exit});
        check("exit_value", exit_value, exp_exit_val);
        check("irq_timer", {31'd0, irq_timer}, {31'd0, irq_at(cyc)});
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) bus_cycle(1'b0, 1'b0, 32'd0, 32'd0, rdy);
    endtask

    // Reset for one cycle with a pending request to confirm it is not granted.
    task automatic do_reset();
        rst = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = ADDR_LEVEL; bus.wdata = '0;
        char_ready = 1'b0;
        q.delete();
        term = 0; kind = 0; exp_exit_val = '0; wr_n = 0; wr_cyc = cyc;
        #1;
        check("rst_gnt", {31'd0, bus.gnt}, 32'd0);
        check("rst_char_valid", {31'd0, char_valid}, 32'd0);
        check("rst_rvalid", {31'd0, bus.rvalid}, 32'd0);
        check("rst_pulses", {29'd0, tests_passed, tests_failed, exit_valid}, 32'd0);
        check("rst_exit_value", exit_value, 32'd0);
        check("rst_irq", {31'd0, irq_timer}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.req = 1'b0;
        cyc++;
    endtask

    initial begin
        logic [31:0] rv;
        int          op;
        logic        rdy;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0; bus.be = 4'hf;
        char_ready = 1'b0;
        @(negedge clk);
        do_reset();

        $display("[TB] print ordering");
        bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h48, 1'b1);
        bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h69, 1'b1);
        idle(3, 1'b1);

        $display("[TB] fifo full back-pressure");
        for (int i = 0; i < 9; i++) bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h30 + 32'(i), 1'b0);
        bus_cycle(1'b1, 1'b0, ADDR_LEVEL, 32'd0, 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h39, 1'b1);
        bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h39, 1'b0);
        bus_cycle(1'b1, 1'b0, ADDR_LEVEL, 32'd0, 1'b0);
        idle(10, 1'b1);

        $display("[TB] pass deferred behind output");
        for (int i = 0; i < 3; i++) bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h61 + 32'(i), 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_STATUS, PASS_MAGIC, 1'b0);
        idle(3, 1'b0);
        idle(6, 1'b1);
        bus_cycle(1'b1, 1'b1, ADDR_EXIT, 32'd9, 1'b1);
        idle(4, 1'b1);

        $display("[TB] exit and fail on empty fifo");
        do_reset();
        bus_cycle(1'b1, 1'b1, ADDR_EXIT, 32'd5, 1'b0);
        idle(4, 1'b0);
        do_reset();
        bus_cycle(1'b1, 1'b1, ADDR_STATUS, 32'd0, 1'b0);
        idle(4, 1'b0);

        $display("[TB] timer");
        bus_cycle(1'b1, 1'b1, ADDR_TIMER, 32'd3, 1'b0);
        for (int i = 0; i < 4; i++) bus_cycle(1'b1, 1'b0, ADDR_TIMER, 32'd0, 1'b0);
        idle(2, 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_TIMER, 32'd0, 1'b0);
        idle(2, 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_TIMER, 32'd2, 1'b0);
        idle(1, 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_TIMER, 32'd4, 1'b0);
        idle(6, 1'b0);

        $display("[TB] reset during drain");
        do_reset();
        bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h41, 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_PRINT, 32'h42, 1'b0);
        bus_cycle(1'b1, 1'b1, ADDR_EXIT, 32'd7, 1'b0);
        idle(1, 1'b0);
        do_reset();
        idle(6, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            op  = int'($urandom_range(0, 11));
            rdy = 1'($urandom_range(0, 1));
            rv  = $urandom;
            case (op)
                0, 1, 2: bus_cycle(1'b1, 1'b1, ADDR_PRINT, rv, rdy);
                3:       bus_cycle(1'b1, 1'b0, ADDR_LEVEL, rv, rdy);
                4:       bus_cycle(1'b1, 1'b0, ADDR_TIMER, rv, rdy);
                5:       bus_cycle(1'b1, 1'b1, ADDR_TIMER, 32'($urandom_range(0, 6)), rdy);
                6:       bus_cycle(1'b1, 1'b0, ADDR_PRINT, rv, rdy);
                7:       bus_cycle(1'b1, 1'($urandom_range(0, 1)), 32'h2000_0008, rv, rdy);
                8:       bus_cycle(1'b1, 1'b0, $urandom, rv, rdy);
                9: begin
                    if ($urandom_range(0, 7) == 0)
                        bus_cycle(1'b1, 1'b1, ($urandom_range(0, 1) == 1) ? ADDR_EXIT : ADDR_STATUS,
                                  ($urandom_range(0, 1) == 1) ? PASS_MAGIC : rv, rdy);
                    else
                        bus_cycle(1'b0, 1'b0, rv, rv, rdy);
                end
                default: bus_cycle(1'b0, 1'b1, ADDR_PRINT, rv, rdy);
            endcase
            if (i % 100 == 99) do_reset();
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cv32e40p_tb_status_periph.md
# cv32e40p_tb_status_periph

Memory-mapped testbench peripheral on the core's data bus inside the testbench subsystem. It produces the pass/fail/exit status that the testbench top samples every clock to end simulation. It buffers stdout characters in a FIFO and defers every termination report until that FIFO has drained, so all printed output precedes `$finish`. It also provides a one-shot countdown timer interrupt.

## Interface
- FIFO_DEPTH, 8: stdout FIFO entries; power of two, ≥2.
- PASS_MAGIC, 32'd123456789: STATUS write value meaning pass.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock, asynchronous and active-high.
- req_i  in  1  bus request.
- we_i  in  1  1 = write.
- addr_i  in  32  byte address.
- wdata_i  in  32  write data.
- be_i  in  4  byte enables; ignored, all accesses are full word.
- gnt_o  out  1  grant; combinational.
- rvalid_o  out  1  response valid.
- rdata_o  out  32  read data.
- char_valid_o  out  1  FIFO non-empty.
- char_o  out  8  FIFO head.
- char_ready_i  in  1  consumer pops when high with char_valid_o.
- tests_passed_o  out  1  pass pulse.
- tests_failed_o  out  1  fail pulse.
- exit_valid_o  out  1  exit pulse.
- exit_value_o  out  32  exit code.
- irq_timer_o  out  1  timer interrupt, level.

## Operation
- Address map, all other addresses: write ignored, read returns 0.
  - 0x1000_0000 PRINT
    - Write pushes wdata_i[7:0] into the FIFO.
    - Read returns 0.
  - 0x1000_0004 LEVEL (RO): read returns the FIFO count.
  - 0x2000_0000 STATUS (WO)
    - A write of PASS_MAGIC requests pass.
    - Any other written value requests fail.
  - 0x2000_0004 EXIT (WO): write requests exit with code wdata_i.
  - 0x1500_0000 TIMER
    - Write N>0: timer_q=N and irq_timer_o cleared.
    - Write 0: timer_q=0 and irq_timer_o cleared.
    - Read returns timer_q.
- Grant: gnt_o = req_i & ~rst_i & ~(PRINT write & FIFO full). All other accesses are granted in the same cycle.
- FIFO:
  - Push on a granted PRINT write; pop on char_valid_o & char_ready_i.
  - Simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - char_o is the head entry; pop order is push order.
- Termination FSM, encoded as IDLE, DRAIN, DONE:
  - IDLE: a granted STATUS or EXIT write captures the request kind and, for EXIT, loads exit_value_o = wdata_i; FSM moves to DRAIN.
  - DRAIN: when the FIFO is empty, the matching output is registered high for exactly one cycle; FSM moves to DONE.
  - DRAIN and DONE: further STATUS/EXIT writes are granted and ignored (first request wins). PRINT writes still push.
  - DONE is terminal until reset.
  - exit_value_o holds its value after capture.
- Timer:
  - While timer_q>0, timer_q decrements by 1 each cycle.
  - On the edge where timer_q goes 1→0, irq_timer_o is set.
  - irq_timer_o stays high until the next TIMER write.

## Timing
- Reset: all registered outputs are 0; FIFO empty; FSM IDLE; timer_q=0.
  - gnt_o is 0 while rst_i is high.
- Reset asserted mid-operation flushes the FIFO and discards any pending termination; no pulse is emitted.
- rvalid_o is high exactly one cycle after each grant, for reads and writes. rdata_o is valid with rvalid_o and 0 otherwise.
- A pushed character is visible on char_o/char_valid_o in the cycle after the grant.
- Termination with the FIFO already empty, grant in cycle t: the pulse is high in cycle t+2.
- Timer write of N in cycle t: timer_q=N in t+1 and irq_timer_o is high from cycle t+N+1.
- A TIMER write in the same cycle as the 1→0 transition wins: the write takes effect and the irq is not set.

## Test plan
- Two PRINT writes, 0x48 then 0x69, with char_ready_i=1
  - char_o shows 0x48, then 0x69, on consecutive cycles.
  - char_valid_o drops afterwards.
- FIFO full, char_ready_i=0
  - 8 PRINT writes are granted; the 9th holds gnt_o=0.
  - Reading LEVEL returns 8.
  - Raising char_ready_i for one cycle grants the 9th write.
- Pass deferred behind queued output
  - Setup: 3 characters queued, char_ready_i=0, then a write of 123456789 to STATUS.
  - tests_passed_o stays 0 until the 3 pops complete, then pulses for one cycle.
  - A later EXIT write produces no exit_valid_o.
- Exit and fail on an empty FIFO
  - Write 5 to EXIT with the FIFO empty: exit_valid_o pulses at t+2 and exit_value_o=5 thereafter.
  - After reset, write 0 to STATUS: tests_failed_o pulses and tests_passed_o stays 0.
- Timer
  - Write 3 to TIMER at t: reads return 3, 2, 1, 0 on successive cycles.
  - irq_timer_o is high from t+4.
  - Write 0 to TIMER: irq_timer_o is low the next cycle.
- Reset during DRAIN
  - Setup: 2 characters pending and an EXIT request captured.
  - Assert rst_i: char_valid_o=0 and no exit_valid_o pulse ever occurs.
